// File: rtl/inst_sram_like_responder.sv
// Responder end of the dual-fetch SRAM-like instruction interface.
// Serves in-order, fixed-latency fetches from a synchronous dual-read-port RAM.
module inst_sram_like_responder #(
  parameter int unsigned ADDR_W          = 14,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned LINE_WORDS      = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req_1,
  input  logic              inst_req_2,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [31:0]       inst_addr_1,
  input  logic [31:0]       inst_addr_2,
  input  logic [31:0]       inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic              second_data_ok,
  output logic [31:0]       inst_rdata_1,
  output logic [31:0]       inst_rdata_2,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr_1,
  output logic [ADDR_W-1:0] mem_addr_2,
  input  logic [31:0]       mem_rdata_1,
  input  logic [31:0]       mem_rdata_2
);

  localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned Depth = 2 ** PtrW;
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(MAX_OUTSTANDING);
  localparam logic [3:0]      AgeSat   = 4'(LATENCY);
  localparam logic [3:0]      AgeDue   = 4'(LATENCY - 1);
  localparam logic [31:0]     LineLast = 32'(LINE_WORDS - 1);
  localparam bit              Bypass   = (LATENCY == 1);

  logic [Depth-1:0] r_valid;
  logic [Depth-1:0] r_pair;
  logic [Depth-1:0] r_wr;
  logic [3:0]       r_age   [Depth];
  logic [31:0]      r_data1 [Depth];
  logic [31:0]      r_data2 [Depth];
  logic [PtrW-1:0]  r_head;
  logic [PtrW-1:0]  r_tail;
  logic [PtrW-1:0]  r_cap_idx;
  logic             r_cap;
  logic [CntW-1:0]  r_count;
  logic [31:0]      r_hold_1;

  logic             w_pop;
  logic             w_accept;
  logic             w_pair;
  logic [31:0]      w_offset;
  logic [31:0]      w_head_d1;
  logic [31:0]      w_head_d2;
  logic             w_unused;

  assign w_unused = ^{inst_size, inst_wdata};

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Constant latency and in-order issue mean only the head can ever be due.
  assign w_pop    = resetn && r_valid[r_head] && (r_age[r_head] == AgeDue);
  assign w_accept = resetn && inst_req_1 && ((r_count < CntMax) || w_pop);
  assign w_offset = (inst_addr_1 >> 2) & LineLast;
  assign w_pair   = inst_req_2 && !inst_wr && (inst_addr_2 == inst_addr_1 + 32'd4) &&
                    (w_offset != LineLast);

  assign w_head_d1 = Bypass ? mem_rdata_1 : r_data1[r_head];
  assign w_head_d2 = Bypass ? mem_rdata_2 : r_data2[r_head];

  assign inst_addr_ok   = w_accept;
  assign inst_data_ok   = w_pop;
  assign second_data_ok = w_pop && r_pair[r_head];
  assign inst_rdata_1   = !resetn ? '0 :
                          w_pop   ? (r_wr[r_head] ? '0 : w_head_d1) : r_hold_1;
  assign inst_rdata_2   = second_data_ok ? w_head_d2 : '0;

  assign mem_en     = w_accept;
  assign mem_addr_1 = w_accept ? inst_addr_1[ADDR_W+1:2] : '0;
  assign mem_addr_2 = w_accept ? inst_addr_2[ADDR_W+1:2] : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid   <= '0;
      r_pair    <= '0;
      r_wr      <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_cap     <= 1'b0;
      r_cap_idx <= '0;
      r_count   <= '0;
      r_hold_1  <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_age[i]   <= '0;
        r_data1[i] <= '0;
        r_data2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (r_valid[i] && (r_age[i] != AgeSat)) r_age[i] <= r_age[i] + 4'd1;
      end
      // RAM data arrives the cycle after the accept that addressed it.
      if (r_cap) begin
        r_data1[r_cap_idx] <= mem_rdata_1;
        r_data2[r_cap_idx] <= mem_rdata_2;
      end
      r_cap     <= w_accept;
      r_cap_idx <= r_tail;
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= ptr_inc(r_head);
        r_hold_1        <= inst_rdata_1;
      end
      if (w_accept) begin
        r_valid[r_tail] <= 1'b1;
        r_pair[r_tail]  <= w_pair;
        r_wr[r_tail]    <= inst_wr;
        r_age[r_tail]   <= '0;
        r_tail          <= ptr_inc(r_tail);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
